// File: rtl/el2_lsu_dccm_rmw_pkg.sv
// Shared types and helpers for the DCCM store-merge / port-arbitration stage.
package el2_lsu_dccm_rmw_pkg;

    localparam int unsigned DCCM_BITS        = 16;
    localparam int unsigned DCCM_BANK_BITS   = 2;
    localparam int unsigned DCCM_DATA_WIDTH  = 32;
    localparam int unsigned DCCM_FDATA_WIDTH = 39;
    localparam int unsigned DCCM_ECC_WIDTH   = DCCM_FDATA_WIDTH - DCCM_DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10
    } rmw_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } st_size_t;

    typedef struct packed {
        logic [DCCM_BITS-1:0]       addr_lo;
        logic [DCCM_BITS-1:0]       addr_hi;
        logic [1:0]                 size;
        logic [DCCM_DATA_WIDTH-1:0] data;
    } st_req_t;

    // Illegal size 3 behaves as a word store.
    function automatic logic [1:0] eff_size(input logic [1:0] size);
        return (size == SZ_ILLEGAL) ? SZ_WORD : size;
    endfunction

    // Last byte address of a store; wraps at the top of the DCCM.
    function automatic logic [DCCM_BITS-1:0] store_addr_hi(input logic [DCCM_BITS-1:0] addr,
                                                           input logic [1:0] size);
        logic [DCCM_BITS-1:0] nbytes;
        nbytes = DCCM_BITS'(1) << eff_size(size);
        return addr + nbytes - DCCM_BITS'(1);
    endfunction

    // Byte enables over {hi word, lo word} for a store starting at byte offset off.
    function automatic logic [7:0] byte_mask(input logic [1:0] off, input logic [1:0] size);
        logic [7:0] m;
        case (eff_size(size))
            SZ_BYTE: m = 8'b0000_0001;
            SZ_HALF: m = 8'b0000_0011;
            default: m = 8'b0000_1111;
        endcase
        return m << off;
    endfunction

    // Right-justified store data with bytes beyond the store size cleared.
    function automatic logic [DCCM_DATA_WIDTH-1:0] size_data(input logic [DCCM_DATA_WIDTH-1:0] data,
                                                             input logic [1:0] size);
        case (eff_size(size))
            SZ_BYTE: return {24'h0, data[7:0]};
            SZ_HALF: return {16'h0, data[15:0]};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/el2_lsu_dccm_rmw_ecc_gen.sv
// 32-bit to 7-bit SECDED check-bit generator (Hamming + overall parity).
module el2_lsu_dccm_ecc_gen
    import el2_lsu_dccm_rmw_pkg::*;
(
    input  logic [DCCM_DATA_WIDTH-1:0] data,
    output logic [DCCM_ECC_WIDTH-1:0]  ecc
);

    logic [5:0] hamming;

    assign hamming[0] = ^(data & 32'h56AA_AD5B);
    assign hamming[1] = ^(data & 32'h9B33_366D);
    assign hamming[2] = ^(data & 32'hE3C3_C78E);
    assign hamming[3] = ^(data & 32'h03FC_07F0);
    assign hamming[4] = ^(data & 32'h03FF_F800);
    assign hamming[5] = ^(data & 32'hFC00_0000);

    assign ecc = {^{data, hamming}, hamming};

endmodule

// File: rtl/el2_lsu_dccm_rmw.sv
// DCCM port owner: arbitrates loads vs stores and merges sub-word/misaligned stores via read-modify-write.
module el2_lsu_dccm_rmw
    import el2_lsu_dccm_rmw_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_l,
    input  logic                        st_valid,
    output logic                        st_ready,
    input  logic [DCCM_BITS-1:0]        st_addr,
    input  logic [1:0]                  st_size,
    input  logic [DCCM_DATA_WIDTH-1:0]  st_data,
    input  logic                        ld_valid,
    input  logic [DCCM_BITS-1:0]        ld_addr_lo,
    input  logic [DCCM_BITS-1:0]        ld_addr_hi,
    output logic                        ld_grant,
    output logic                        ld_rd_valid,
    output logic [DCCM_FDATA_WIDTH-1:0] ld_rd_data_lo,
    output logic [DCCM_FDATA_WIDTH-1:0] ld_rd_data_hi,
    output logic                        dccm_wren,
    output logic                        dccm_rden,
    output logic [DCCM_BITS-1:0]        dccm_wr_addr_lo,
    output logic [DCCM_BITS-1:0]        dccm_wr_addr_hi,
    output logic [DCCM_BITS-1:0]        dccm_rd_addr_lo,
    output logic [DCCM_BITS-1:0]        dccm_rd_addr_hi,
    output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_lo,
    output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_hi,
    input  logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_lo,
    input  logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_hi,
    output logic                        busy
);

    rmw_state_t state, state_nxt;
    st_req_t    req_q, req_d;
    logic [7:0] mask_q, mask_d;

    logic                       misaligned;
    logic [63:0]                st_shift;
    logic [63:0]                rd_word;
    logic [63:0]                merged;
    logic [DCCM_ECC_WIDTH-1:0]  ecc_lo, ecc_hi;

    assign busy          = (state != IDLE);
    assign ld_rd_data_lo = dccm_rd_data_lo;
    assign ld_rd_data_hi = dccm_rd_data_hi;
    assign misaligned    = (req_q.addr_lo[DCCM_BITS-1:2] != req_q.addr_hi[DCCM_BITS-1:2]);

    // Byte merge of store data over the old words read in RD (ECC bits of the read are ignored).
    assign st_shift = 64'(size_data(req_q.data, req_q.size)) << {req_q.addr_lo[1:0], 3'b000};
    assign rd_word  = {dccm_rd_data_hi[DCCM_DATA_WIDTH-1:0], dccm_rd_data_lo[DCCM_DATA_WIDTH-1:0]};

    always_comb begin
        merged = rd_word;
        for (int b = 0; b < 8; b++) begin
            if (mask_q[b]) merged[8*b +: 8] = st_shift[8*b +: 8];
        end
    end

    el2_lsu_dccm_ecc_gen u_ecc_lo (.data(merged[31:0]),  .ecc(ecc_lo));
    el2_lsu_dccm_ecc_gen u_ecc_hi (.data(merged[63:32]), .ecc(ecc_hi));

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state       <= IDLE;
            req_q       <= '0;
            mask_q      <= '0;
            ld_rd_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            req_q       <= req_d;
            mask_q      <= mask_d;
            ld_rd_valid <= ld_grant;
        end
    end

    always_comb begin
        state_nxt       = state;
        req_d           = req_q;
        mask_d          = mask_q;
        ld_grant        = 1'b0;
        st_ready        = 1'b0;
        dccm_rden       = 1'b0;
        dccm_rd_addr_lo = '0;
        dccm_rd_addr_hi = '0;
        dccm_wren       = 1'b0;
        dccm_wr_addr_lo = '0;
        dccm_wr_addr_hi = '0;
        dccm_wr_data_lo = '0;
        dccm_wr_data_hi = '0;
        case (state)
            IDLE: begin
                ld_grant = ld_valid;
                st_ready = ~ld_valid;
                if (ld_valid) begin
                    dccm_rden       = 1'b1;
                    dccm_rd_addr_lo = ld_addr_lo;
                    dccm_rd_addr_hi = ld_addr_hi;
                end else if (st_valid) begin
                    req_d.addr_lo = st_addr;
                    req_d.addr_hi = store_addr_hi(st_addr, st_size);
                    req_d.size    = st_size;
                    req_d.data    = st_data;
                    mask_d        = byte_mask(st_addr[1:0], st_size);
                    state_nxt     = (eff_size(st_size) == SZ_WORD && st_addr[1:0] == 2'b00) ? WR : RD;
                end
            end
            RD: begin
                dccm_rden       = 1'b1;
                dccm_rd_addr_lo = req_q.addr_lo;
                dccm_rd_addr_hi = req_q.addr_hi;
                state_nxt       = WR;
            end
            WR: begin
                dccm_wren       = 1'b1;
                dccm_wr_addr_lo = req_q.addr_lo;
                dccm_wr_addr_hi = req_q.addr_hi;
                dccm_wr_data_lo = {ecc_lo, merged[31:0]};
                dccm_wr_data_hi = misaligned ? {ecc_hi, merged[63:32]} : {ecc_lo, merged[31:0]};
                state_nxt       = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
